// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential multiplier datapath.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DIGIT_W = 2;
    localparam int unsigned PP_W    = 4;

endpackage

// File: rtl/mult2x2.sv
// Exact combinational 2-bit x 2-bit -> 4-bit unsigned multiplier core.
module mult2x2
    import mult_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic [PP_W-1:0]    p
);

    assign p = PP_W'(a) * PP_W'(b);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Iterative unsigned multiplier: walks all 2-bit digit pairs through one shared
// 2x2 core and accumulates shifted partial products, with valid/ready on both sides.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int unsigned D     = WIDTH / 2;
    localparam int unsigned CNT_W = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned P_W   = 2 * WIDTH;
    localparam int unsigned SH_W  = CNT_W + 2;

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [P_W-1:0]     acc;
    logic [CNT_W-1:0]   i;
    logic [CNT_W-1:0]   j;

    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [PP_W-1:0]    pp;
    logic [SH_W-1:0]    sh;
    logic [P_W-1:0]     acc_next;
    logic               j_last;
    logic               last;

    // Digit select from the latched operands, so input changes never reach the core.
    assign a_dig = a_r[i*DIGIT_W +: DIGIT_W];
    assign b_dig = b_r[j*DIGIT_W +: DIGIT_W];

    mult2x2 u_core (
        .a (a_dig),
        .b (b_dig),
        .p (pp)
    );

    // Partial product weight is 4^(i+j), i.e. a left shift by 2*(i+j).
    assign sh       = {(CNT_W + 1)'(i) + (CNT_W + 1)'(j), 1'b0};
    assign acc_next = acc + (P_W'(pp) << sh);
    assign j_last   = (j == CNT_W'(D - 1));
    assign last     = j_last && (i == CNT_W'(D - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_p     <= '0;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            i         <= '0;
            j         <= '0;
        end else if (clear) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            acc       <= '0;
            i         <= '0;
            j         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= in_a;
                        b_r      <= in_b;
                        acc      <= '0;
                        i        <= '0;
                        j        <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (last) begin
                        i         <= '0;
                        j         <= '0;
                        out_p     <= acc_next;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else if (j_last) begin
                        j <= '0;
                        i <= i + CNT_W'(1);
                    end else begin
                        j <= j + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: vector table, random sweep against a
// plain-arithmetic product model, and hand-written abort/reset/back-pressure sequences.
module tb_mult_seq_ctrl;
    import mult_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        busy;

    logic [1:0]  ca;
    logic [1:0]  cb;
    logic [3:0]  cp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    mult2x2 u_core_chk (
        .a (ca),
        .b (cb),
        .p (cp)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          hold;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full request: accept, check latency and product, optional back-pressure, consume.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = (hold == 0);
        step();
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        chk("in_ready_after_accept", 32'(in_ready), 32'd0);
        chk("busy_run", 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        chk("latency", 32'(n), 32'd16);
        chk("product", 32'(out_p), 32'(exp));
        for (int k = 0; k < hold; k++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_p", 32'(out_p), 32'(exp));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        chk("valid_before_consume", 32'(out_valid), 32'd1);
        step();
        chk("valid_after_consume", 32'(out_valid), 32'd0);
        chk("in_ready_after_consume", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0] = '{8'd13,  8'd11,  16'd143,  0};
        vecs[1] = '{8'hFF,  8'hFF,  16'hFE01, 0};
        vecs[2] = '{8'h00,  8'hA5,  16'h0000, 0};
        vecs[3] = '{8'h01,  8'h80,  16'h0080, 0};
        vecs[4] = '{8'h80,  8'h80,  16'h4000, 0};
        vecs[5] = '{8'hFF,  8'h02,  16'h01FE, 5};

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; ca = '0; cb = '0;

        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                ca = 2'(x);
                cb = 2'(y);
                #1;
                chk("core2x2", 32'(cp), 32'(x * y));
            end
        end

        #20;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_p", 32'(out_p), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 6; v++)
            run_txn(vecs[v].a, vecs[v].b, vecs[v].p, vecs[v].hold);

        // Abort on RUN cycle 7: no result may appear.
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
        step();
        in_valid = 1'b0;
        repeat (6) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) seen++;
            step();
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        run_txn(8'd6, 8'd7, 16'd42, 0);

        for (int r = 0; r < 20; r++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_txn(ra, rb, 16'(ra) * 16'(rb), int'($urandom_range(0, 3)));
        end

        // Async reset mid-RUN, away from the clock edge.
        in_valid = 1'b1; in_a = 8'd100; in_b = 8'd100;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out_p", 32'(out_p), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back with in_valid held high.
        in_valid = 1'b1; in_a = 8'd200; in_b = 8'd3; out_ready = 1'b1;
        step();
        in_a = 8'd255; in_b = 8'd1;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        chk("b2b_latency1", 32'(n), 32'd16);
        chk("b2b_p1", 32'(out_p), 32'd600);
        step();
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        chk("b2b_spacing", 32'(n + 2), 32'd18);
        chk("b2b_p2", 32'(out_p), 32'd255);
        step();
        chk("b2b_done", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Iterative unsigned multiplier controller that computes a WIDTH×WIDTH product by sequencing one shared 2×2 multiplier core over all digit pairs of the operands. It accumulates shifted partial products in a register. Upstream and downstream connect through valid/ready handshakes. It sits between the operand source and the result consumer in the mult/div datapath, and trades area for latency.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥ 4.
- D (localparam), WIDTH/2, number of 2-bit digits per operand.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort; returns the block to IDLE
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- in_a  in  WIDTH  multiplicand, unsigned
- in_b  in  WIDTH  multiplier, unsigned
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_p  out  2·WIDTH  product, unsigned
- busy  out  1  high in RUN or DONE

## Operation
- **States**: IDLE, RUN, DONE.
- **Reset values**:
  - state = IDLE, so in_ready = 1, out_valid = 0, busy = 0.
  - out_p = 0; digit counters i = j = 0; operand registers = 0.
- **IDLE**: in_ready = 1. On in_valid & in_ready:
  - latch in_a and in_b;
  - clear the accumulator;
  - set i = j = 0;
  - go to RUN.
- **RUN**: one digit pair per cycle.
  - pp = mult2x2(a[2i+1:2i], b[2j+1:2j]), a 4-bit product.
  - acc ← acc + (zero-extend(pp) << 2·(i+j)), computed modulo 2^(2·WIDTH); the true product never overflows.
  - j increments; when j = D−1, j wraps to 0 and i increments.
  - On the cycle with i = D−1 and j = D−1, the final add is registered and the state goes to DONE.
- **DONE**:
  - out_valid = 1 and out_p = acc.
  - out_p holds stable while out_ready = 0.
  - On out_valid & out_ready, go to IDLE.
- **clear**:
  - from any state, go to IDLE at the next edge;
  - out_valid drops, counters reset, and any in-flight result is discarded;
  - clear has priority over handshakes in the same cycle.
- **Operand stability**: in_a and in_b are ignored outside the accept cycle. The operand registers isolate the core from input changes.
- **No overlap**: a new request is not accepted while RUN or DONE is active (in_ready = 0).
- **rst_n mid-operation**: immediate return to the reset values. No result is produced.

## Timing
- All outputs are driven from registers or decoded from state only. There is no combinational path from in_* or out_ready to any output.
- **Latency**:
  - accept edge at T0;
  - RUN occupies D² cycles;
  - out_valid goes high after edge T0 + D². For WIDTH = 8 that is 16 cycles after accept.
- **Throughput**:
  - with out_ready held high, one result per D² + 2 cycles (RUN D², DONE 1, IDLE 1);
  - for WIDTH = 8 that is 18 cycles.
- in_ready deasserts on the edge after accept. out_valid deasserts on the edge after the output handshake.
- **Back-to-back**: in_valid held high while returning to IDLE is accepted in the first IDLE cycle.

## Structure
- **Shared package mult_pkg**:
  - state typedef with 2-bit encoding IDLE = 0, RUN = 1, DONE = 2;
  - constant DIGIT_W = 2;
  - constant PP_W = 4.
- **Sub-module mult2x2**:
  - combinational 2×2 → 4-bit exact multiplier;
  - the carry from the cross terms must propagate into p[2] and p[3], e.g. 3×3 = 4'b1001;
  - one instance, driven by the digit muxes.
- **Controller body**: digit muxes, shifter, adder, accumulator, counters and FSM live in mult_seq_ctrl.

## Test plan
- **mult2x2 exhaustive**: all 16 input pairs → correct products, in particular 3×3 → 9 and 2×3 → 6.
- **Basic (WIDTH = 8)**: a = 13, b = 11 with out_ready = 1 → out_p = 143 (0x008F); out_valid rises exactly 16 cycles after accept; then in_ready = 1.
- **Corners**:
  - 0xFF × 0xFF → 0xFE01;
  - 0 × 0xA5 → 0;
  - 1 × 0x80 → 0x0080;
  - 0x80 × 0x80 → 0x4000;
  - random sweep against a reference model.
- **Back-pressure**: 0xFF × 0x02, out_ready low for 5 cycles → out_valid stays 1, out_p holds 0x01FE, in_ready stays 0; then consumed on the first out_ready cycle.
- **Abort**: clear pulsed on RUN cycle 7 → IDLE next edge, no out_valid. A following 6 × 7 request → 42 with normal latency.
- **Async reset**: rst_n pulled low mid-RUN, asynchronous to clk → outputs at reset values immediately. After release, back-to-back requests 200 × 3 → 600 and 255 × 1 → 255 complete at 18-cycle spacing.
